// File: rtl/cve2_pkg.sv
// Shared cve2 definitions used by the hardware-loop controller.
package cve2_pkg;

    localparam int unsigned HWLP_ADDR_W = 32;

    typedef enum logic [0:0] {
        HWLP_IDLE = 1'b0,
        HWLP_JUMP = 1'b1
    } hwlp_ctrl_state_e;

endpackage

// File: rtl/cve2_hwloop_sel.sv
// End-address match and lowest-index-first loop selection.
import cve2_pkg::*;

module cve2_hwloop_sel #(
    parameter int unsigned N_REGS     = 2,
    parameter int unsigned N_REG_BITS = $clog2(N_REGS)
) (
    input  logic [HWLP_ADDR_W-1:0]             pc,
    input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0] end_addr,
    input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0] counter,
    output logic                               hit,
    output logic [N_REG_BITS-1:0]              sel,
    output logic                               sel_cnt_gt1
);

    // Scan from the outermost loop down so the innermost match is the one kept.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = N_REGS - 1; k >= 0; k--) begin
            if ((pc == end_addr[k]) && (counter[k] != '0)) begin
                hit = 1'b1;
                sel = N_REG_BITS'(k);
            end
        end
    end

    assign sel_cnt_gt1 = counter[sel] > HWLP_ADDR_W'(1);

endmodule

// File: rtl/cve2_hwloop_ctrl.sv
// Hardware-loop sequencing: decrement strobe to the loop register file and
// a held redirect request to fetch.
//
// state     | meaning
// HWLP_IDLE | watching ID for a loop-end hit
// HWLP_JUMP | redirect to target_q pending until fetch accepts or flush
import cve2_pkg::*;

module cve2_hwloop_ctrl #(
    parameter int unsigned N_REGS     = 2,
    parameter int unsigned N_REG_BITS = $clog2(N_REGS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [HWLP_ADDR_W-1:0]             pc_id_i,
    input  logic                               id_valid_i,
    input  logic                               id_done_i,
    input  logic                               flush_i,
    input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0] hwlp_start_addr_i,
    input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0] hwlp_end_addr_i,
    input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0] hwlp_counter_i,
    input  logic                               fetch_ready_i,
    output logic                               hwlp_jump_o,
    output logic [HWLP_ADDR_W-1:0]             hwlp_target_o,
    output logic [N_REGS-1:0]                  hwlp_dec_cnt_o,
    output logic                               hwlp_busy_o
);

    hwlp_ctrl_state_e       state_q;
    logic [HWLP_ADDR_W-1:0] target_q;
    logic                   hit;
    logic [N_REG_BITS-1:0]  sel;
    logic                   sel_cnt_gt1;
    logic                   dec_fire;
    logic                   jump_take;

    cve2_hwloop_sel #(
        .N_REGS     (N_REGS),
        .N_REG_BITS (N_REG_BITS)
    ) u_sel (
        .pc          (pc_id_i),
        .end_addr    (hwlp_end_addr_i),
        .counter     (hwlp_counter_i),
        .hit         (hit),
        .sel         (sel),
        .sel_cnt_gt1 (sel_cnt_gt1)
    );

    // Gated by rst so the strobe is quiet for the whole reset assertion.
    assign dec_fire  = !rst && (state_q == HWLP_IDLE) && id_valid_i && id_done_i && hit;
    assign jump_take = dec_fire && sel_cnt_gt1;

    assign hwlp_dec_cnt_o = dec_fire ? (N_REGS'(1) << sel) : '0;
    assign hwlp_jump_o    = (state_q == HWLP_JUMP);
    assign hwlp_busy_o    = (state_q == HWLP_JUMP);
    assign hwlp_target_o  = (state_q == HWLP_JUMP) ? target_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HWLP_IDLE;
            target_q <= '0;
        end else begin
            case (state_q)
                HWLP_IDLE: begin
                    if (jump_take) begin
                        target_q <= hwlp_start_addr_i[sel];
                        state_q  <= HWLP_JUMP;
                    end
                end
                HWLP_JUMP: begin
                    if (flush_i || fetch_ready_i) begin
                        state_q <= HWLP_IDLE;
                    end
                end
                default: state_q <= HWLP_IDLE;
            endcase
        end
    end

endmodule
